// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tartaruga_pkg;

    // Generic 32-bit datapath word used across the core.
    typedef logic [31:0] bus32_t;

    // Default PC loaded on reset. It must be word aligned.
    localparam bus32_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Default fetch queue depth. It must be a power of two and at least 2.
    localparam int FETCH_QUEUE_DEPTH = 2;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        bus32_t pc;
        bus32_t instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so the result is a word address.
    function automatic bus32_t word_align(input bus32_t addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential next-PC. It wraps modulo 2^32.
    function automatic bus32_t pc_incr(input bus32_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// FIFO of fetched {pc, instr} entries sitting between PC generation and decode.
// Latency: an entry written at a clock edge is visible at the head output after that edge.
// Backpressure: an enqueue is refused when full unless a dequeue happens in the same cycle; flush wins over everything.
module fetch_queue
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         enq_i,
    input  fetch_entry_t enq_dat_i,
    input  logic         deq_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_enq;
    logic             do_deq;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

    // A dequeue needs something to remove. An enqueue into a full queue is
    // only legal when the head leaves in the same cycle.
    assign do_deq = deq_i & ~flush_i & ~empty_o;
    assign do_enq = enq_i & ~flush_i & (~full_o | do_deq);

    // Next pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage. It needs no reset because the head output is masked when empty.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem_q[tail_q] <= enq_dat_i;
        end
    end

    // Head entry, forced to zero when empty so stale data never leaks out.
    always_comb begin
        head_o = '0;
        if (!empty_o) begin
            head_o = mem_q[head_q];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC generation plus fetch buffer: addresses instruction memory and queues {pc, instr} for decode.
// Latency: a new PC shows up at decode one cycle later when the queue is empty; throughput is 1 instr/cycle.
// Backpressure: ready_i low fills the queue, then the PC freezes; a redirect flushes the queue and masks valid_o.
module fetch_stage
    import tartaruga_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        ready_i,
    output logic [31:0] fetch_count_o
);

    bus32_t       pc_q;
    bus32_t       pc_d;
    bus32_t       fetch_count_q;
    bus32_t       fetch_count_d;
    logic         enq;
    logic         deq;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t enq_entry;
    fetch_entry_t head_entry;

    // Decode only sees the head when the queue holds something and no
    // redirect is in flight, so a wrong-path instruction is never accepted.
    assign valid_o = ~q_empty & ~redirect_i;
    assign deq     = valid_o & ready_i & ~redirect_i;

    // Fetch when there is room, or when the head leaves in this same cycle.
    assign enq = ~redirect_i & (~q_full | deq);

    // The memory read is combinational, so the returned word pairs with the current PC.
    always_comb begin
        enq_entry       = '0;
        enq_entry.pc    = pc_q;
        enq_entry.instr = instr_i;
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .enq_i     (enq),
        .enq_dat_i (enq_entry),
        .deq_i     (deq),
        .flush_i   (redirect_i),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .head_o    (head_entry)
    );

    // Next PC: a redirect takes priority, then sequential advance on enqueue, else stall.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (enq) begin
            pc_d = pc_incr(pc_q);
        end
    end

    // Count every instruction that actually lands in the queue.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (enq) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // PC and fetch counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_count_o = fetch_count_q;
    assign instr_o       = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational memory model.
// Each step drives inputs just after a rising edge and checks outputs mid-cycle.
// Expected values are hand-computed from the fetch/queue/redirect rules.
module tb_fetch_stage;

    logic        clk_i;
    logic        rstn_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        ready_i;
    logic [31:0] fetch_count_o;

    int vectors;
    int miscompares;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .ready_i       (ready_i),
        .fetch_count_o (fetch_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction memory model: the word encodes its own address.
    always_comb instr_i = 32'hDEAD_0000 | {16'h0000, pc_o[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i       = 1'b1;

        // Reset state
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_ipc", instr_pc_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_cnt", fetch_count_o, 32'h0);

        // 1. Reset release with ready high: one instruction per cycle
        tick(); tick();
        rstn_i = 1'b1; #1;
        chk("t1_c0_pc", pc_o, 32'h0);
        chk("t1_c0_valid", {31'b0, valid_o}, 32'h0);
        chk("t1_c0_cnt", fetch_count_o, 32'h0);
        tick();
        chk("t1_c1_valid", {31'b0, valid_o}, 32'h1);
        chk("t1_c1_ipc", instr_pc_o, 32'h0);
        chk("t1_c1_instr", instr_o, 32'hDEAD_0000);
        chk("t1_c1_cnt", fetch_count_o, 32'h1);
        tick();
        chk("t1_c2_ipc", instr_pc_o, 32'h4);
        chk("t1_c2_instr", instr_o, 32'hDEAD_0004);
        chk("t1_c2_cnt", fetch_count_o, 32'h2);
        chk("t1_c2_pc", pc_o, 32'h8);

        // 2. Fresh reset with ready low: queue fills with 0x0 and 0x4, PC freezes at 0x8
        rstn_i  = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("t2_async_rst_pc", pc_o, 32'h0);
        tick();
        rstn_i = 1'b1;
        repeat (5) tick();
        chk("t2_pc_frozen", pc_o, 32'h8);
        chk("t2_cnt", fetch_count_o, 32'h2);
        chk("t2_valid", {31'b0, valid_o}, 32'h1);
        chk("t2_head0", instr_pc_o, 32'h0);

        // 3. Full queue, ready high for one cycle: enq and deq together
        ready_i = 1'b1; #1;
        chk("t3_head0", instr_pc_o, 32'h0);
        tick();
        ready_i = 1'b0; #1;
        chk("t3_head4", instr_pc_o, 32'h4);
        chk("t3_pc_c", pc_o, 32'hC);
        chk("t3_cnt", fetch_count_o, 32'h3);
        tick();
        // Still full (0x4, 0x8), so the PC must not move
        chk("t3_pc_hold", pc_o, 32'hC);
        chk("t3_cnt_hold", fetch_count_o, 32'h3);
        chk("t3_head4_hold", instr_pc_o, 32'h4);

        // 4. Redirect to 0x103 while full
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        #1;
        chk("t4_valid_masked", {31'b0, valid_o}, 32'h0);
        tick();
        redirect_i = 1'b0; #1;
        chk("t4_pc_100", pc_o, 32'h100);
        chk("t4_empty", {31'b0, valid_o}, 32'h0);
        chk("t4_empty_ipc", instr_pc_o, 32'h0);
        chk("t4_cnt_unchanged", fetch_count_o, 32'h3);
        tick();
        chk("t4_valid", {31'b0, valid_o}, 32'h1);
        chk("t4_ipc", instr_pc_o, 32'h100);
        chk("t4_instr", instr_o, 32'hDEAD_0100);
        chk("t4_cnt", fetch_count_o, 32'h4);

        // 5. Back-to-back redirects 0x200 then 0x300
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_pc_i = 32'h300; #1;
        chk("t5_pc_200", pc_o, 32'h200);
        chk("t5_valid_masked", {31'b0, valid_o}, 32'h0);
        tick();
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        #1;
        chk("t5_pc_300", pc_o, 32'h300);
        chk("t5_empty", {31'b0, valid_o}, 32'h0);
        tick();
        chk("t5_valid", {31'b0, valid_o}, 32'h1);
        chk("t5_ipc", instr_pc_o, 32'h300);
        chk("t5_instr", instr_o, 32'hDEAD_0300);
        chk("t5_cnt", fetch_count_o, 32'h5);

        // 6. PC wrap at the top of the address space, then async reset mid-stall
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        ready_i    = 1'b0;
        #1;
        chk("t6_pc_top", pc_o, 32'hFFFF_FFFC);
        chk("t6_cnt_pre", fetch_count_o, 32'h5);
        tick();
        chk("t6_pc_wrap", pc_o, 32'h0);
        chk("t6_ipc", instr_pc_o, 32'hFFFF_FFFC);
        chk("t6_instr", instr_o, 32'hDEAD_FFFC);
        chk("t6_cnt", fetch_count_o, 32'h6);
        tick();
        tick();
        chk("t6_stall_pc", pc_o, 32'h4);
        chk("t6_stall_cnt", fetch_count_o, 32'h7);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, valid_o}, 32'h0);
        chk("t6_rst_pc", pc_o, 32'h0);
        chk("t6_rst_instr", instr_o, 32'h0);
        chk("t6_rst_ipc", instr_pc_o, 32'h0);
        chk("t6_rst_cnt", fetch_count_o, 32'h0);
        tick();
        rstn_i = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
